// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
// Provides the fetch FSM state enum, the response record carried through
// the response FIFO, latency bounds and the NOP word returned on errors.
package ifetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    // One completed fetch: byte address, returned word, error flag.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;
    // Latency counter only has to hold LAT-1, at most LAT_MAX-1.
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/ifetch_rsp_fifo.sv
// Purpose : synchronous FIFO of rsp_t records between the fetch engine and the consumer.
// Latency : a push is visible at the head after the pushing edge; the head is combinational from storage.
// Backpr. : full_o tells the producer to stop; push while full is dropped, pop while empty is ignored.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   push_i/push_dat_i write request and record
//   pop_i             remove the head entry
//   flush_i           empty the FIFO on this edge; overrides push and pop
//   full_o, empty_o   occupancy flags
//   head_o            head record, all-zero while empty
module ifetch_rsp_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  rsp_t push_dat_i,
    input  logic pop_i,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    output rsp_t head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    rsp_t        r_mem [DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign empty_o = (r_wptr == r_rptr);

    assign w_do_push = push_i && !full_o  && !flush_i;
    assign w_do_pop  = pop_i  && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= push_dat_i;
    end

    assign head_o = empty_o ? '0 : r_mem[r_rptr[PW-1:0]];

endmodule

// File: rtl/instr_fetch_responder.sv
// Purpose : instruction-side responder; returns the addressed word of an internal store per fetch request.
// Latency : accept on edge T, response at the FIFO head after edge T+LAT (FIFO empty); one request per LAT+1 cycles.
// Backpr. : req_ready_o drops while a request is outstanding, the response FIFO is full, or flush_i is high.
//
// Parameters: DEPTH words in the store, LAT read latency (1..7), FIFO_DEPTH response entries (power of two, >= 2).
// Optional build macro IFETCH_MISALIGN_TRAP_EN: misaligned fetches complete as error responses.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_addr_i fetch request handshake and byte address
//   rsp_valid_o/rsp_ready_i            response handshake (FIFO head)
//   rsp_instr_o/rsp_addr_o/rsp_err_o   head word, its byte address, error flag
//   flush_i                            drop the outstanding fetch and all buffered responses
//   busy_o                             a fetch is outstanding
//   mem_we_i/mem_waddr_i/mem_wdata_i   loader write port into the store
module instr_fetch_responder
    import ifetch_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic [31:0] rsp_addr_o,
    output logic        rsp_err_o,
    input  logic        flush_i,
    output logic        busy_o,
    input  logic        mem_we_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    // ---------------- instruction store ----------------
    logic [31:0] r_mem [DEPTH];
    logic        w_wr_in_range;
    logic        w_unused;

    assign w_wr_in_range = ({2'b00, mem_waddr_i[31:2]} < 32'(DEPTH));
    assign w_unused      = ^mem_waddr_i[1:0];

    // Loader writes ignore the fetch FSM; writes beyond the store are dropped.
    always_ff @(posedge clk_i) begin
        if (mem_we_i && w_wr_in_range) r_mem[mem_waddr_i[AW+1:2]] <= mem_wdata_i;
    end

    // ---------------- fetch FSM ----------------
    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_addr;
    logic [31:0]      w_addr_nxt;
    logic             w_push;
    logic             w_req_ready;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_rd_in_range;
    logic             w_rd_err;
    rsp_t             w_push_dat;
    rsp_t             w_head;

    assign w_rd_in_range = ({2'b00, r_addr[31:2]} < 32'(DEPTH));

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign w_rd_err = !w_rd_in_range || (r_addr[1:0] != 2'b00);
`else
    assign w_rd_err = !w_rd_in_range;
`endif

    // Combinational read of the store: a loader write on the completion edge
    // lands after this value is captured into the FIFO, so the old word is returned.
    always_comb begin
        w_push_dat       = '0;
        w_push_dat.addr  = r_addr;
        w_push_dat.err   = w_rd_err;
        w_push_dat.instr = w_rd_err ? NOP_WORD : r_mem[r_addr[AW+1:2]];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_push      = 1'b0;
        w_req_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A free FIFO slot is reserved at accept, so completion never meets a full FIFO.
                w_req_ready = !w_fifo_full && !flush_i;
                if (req_valid_i && w_req_ready) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                    w_addr_nxt  = req_addr_i;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- response FIFO ----------------
    ifetch_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push),
        .push_dat_i (w_push_dat),
        .pop_i      (rsp_ready_i),
        .flush_i    (flush_i),
        .full_o     (w_fifo_full),
        .empty_o    (w_fifo_empty),
        .head_o     (w_head)
    );

    assign req_ready_o = w_req_ready;
    assign busy_o      = (r_state == WAIT);
    assign rsp_valid_o = !w_fifo_empty;
    assign rsp_instr_o = w_head.instr;
    assign rsp_addr_o  = w_head.addr;
    assign rsp_err_o   = w_head.err;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_responder;

    localparam int DEPTH      = 256;
    localparam int LAT        = 2;
    localparam int FIFO_DEPTH = 2;

    logic        clk;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        busy;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    instr_fetch_responder #(
        .DEPTH      (DEPTH),
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_instr_o (rsp_instr),
        .rsp_addr_o  (rsp_addr),
        .rsp_err_o   (rsp_err),
        .flush_i     (flush),
        .busy_o      (busy),
        .mem_we_i    (mem_we),
        .mem_waddr_i (mem_waddr),
        .mem_wdata_i (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem_m [DEPTH];
    exp_t        q [$];
    vec_t        vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_waddr = 32'(idx) << 2;
        mem_wdata = d;
        step();
        mem_we = 1'b0;
        if (idx < DEPTH) mem_m[idx] = d;
    endtask

    // Hold a request until it is accepted; returns just after the accept edge.
    task automatic issue(input logic [31:0] a);
        bit ok;
        ok        = 1'b0;
        req_addr  = a;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (req_ready) ok = 1'b1;
            step();
        end
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout addr=%h req_ready=0 required=1", a);
        end
    endtask

    // Single fetch with exact-cycle latency checks, then pop.
    task automatic run_single(input string nm, input logic [31:0] a,
                              input logic [31:0] e_instr, input logic e_err);
        rsp_ready = 1'b0;
        #1;
        chk({nm, "_ready_idle"}, req_ready, 1);
        issue(a);
        #1;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_early_valid"}, rsp_valid, 0);
        for (int i = 1; i < LAT; i++) begin
            step();
            #1;
            chk({nm, "_early_valid"}, rsp_valid, 0);
        end
        step();
        #1;
        chk({nm, "_valid"}, rsp_valid, 1);
        chk({nm, "_instr"}, rsp_instr, e_instr);
        chk({nm, "_addr"}, rsp_addr, a);
        chk({nm, "_err"}, rsp_err, e_err);
        chk({nm, "_busy_done"}, busy, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk({nm, "_popped"}, rsp_valid, 0);
    endtask

    function automatic exp_t model_rsp(input logic [31:0] a);
        exp_t r;
        r.addr = a;
        r.err  = ({2'b00, a[31:2]} >= 32'(DEPTH));
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (a[1:0] != 2'b00) r.err = 1'b1;
`endif
        if (r.err) r.instr = 32'h0;
        else       r.instr = mem_m[a[31:2]];
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h2001_000A, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h1111_1111, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h2222_2222, 1'b0};
        vecs[3] = '{32'h0000_03FC, 32'hFFFF_0001, 1'b0};
        vecs[4] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
`ifdef IFETCH_MISALIGN_TRAP_EN
        vecs[6] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h0000_000E, 32'h0000_0000, 1'b1};
`else
        vecs[6] = '{32'h0000_0002, 32'h2001_000A, 1'b0};
        vecs[7] = '{32'h0000_000E, 32'h3333_3333, 1'b0};
`endif

        rst_i = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

        // Reset state
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_instr", rsp_instr, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        step();
        rst_i = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        load(0, 32'h2001_000A);
        load(1, 32'h1111_1111);
        load(2, 32'h2222_2222);
        load(3, 32'h3333_3333);
        load(5, 32'h5555_5555);
        load(255, 32'hFFFF_0001);
        load(256, 32'hBAD0_BAD0);   // beyond the store: must be dropped

        // Directed vector table
        for (int i = 0; i < 8; i++)
            run_single($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err);

        // Back-pressure: two responses buffered, third request stalls until drain
        rsp_ready = 1'b0;
        issue(32'h0);
        repeat (LAT) step();
        issue(32'h4);
        repeat (LAT) step();
        req_addr  = 32'h8;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready_full", req_ready, 0);
            chk("bp_head_addr", rsp_addr, 32'h0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_head0_instr", rsp_instr, 32'h2001_000A);
        chk("bp_ready_still_full", req_ready, 0);
        step();
        #1;
        chk("bp_head1_addr", rsp_addr, 32'h4);
        chk("bp_head1_instr", rsp_instr, 32'h1111_1111);
        chk("bp_ready_after_pop", req_ready, 1);
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("bp_empty_after_drain", rsp_valid, 0);
        chk("bp_third_busy", busy, 1);
        repeat (LAT) step();
        #1;
        chk("bp_third_valid", rsp_valid, 1);
        chk("bp_third_addr", rsp_addr, 32'h8);
        chk("bp_third_instr", rsp_instr, 32'h2222_2222);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Flush one cycle after accept
        issue(32'h0);
        flush = 1'b1;
        #1;
        chk("flush_ready_low", req_ready, 0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_valid", rsp_valid, 0);
        chk("flush_ready_back", req_ready, 1);
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            #1;
            chk("flush_no_rsp", rsp_valid, 0);
        end

        // Flush of a buffered response, with a simultaneous (void) pop
        issue(32'h4);
        repeat (LAT) step();
        #1;
        chk("flushbuf_valid", rsp_valid, 1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        step();
        flush     = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("flushbuf_empty", rsp_valid, 0);

        // Loader write one edge before completion is visible
        issue(32'h14);
        repeat (LAT - 2) step();
        mem_we = 1'b1; mem_waddr = 32'h14; mem_wdata = 32'hDEAD_BEEF;
        step();
        mem_we = 1'b0;
        mem_m[5] = 32'hDEAD_BEEF;
        step();
        #1;
        chk("wr_early_valid", rsp_valid, 1);
        chk("wr_early_instr", rsp_instr, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Loader write on the completion edge is not visible
        load(5, 32'h5555_5555);
        issue(32'h14);
        repeat (LAT - 1) step();
        mem_we = 1'b1; mem_waddr = 32'h14; mem_wdata = 32'hDEAD_BEEF;
        step();
        mem_we = 1'b0;
        mem_m[5] = 32'hDEAD_BEEF;
        #1;
        chk("wr_same_valid", rsp_valid, 1);
        chk("wr_same_instr", rsp_instr, 32'h5555_5555);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        run_single("wr_same_after", 32'h14, 32'hDEAD_BEEF, 1'b0);

        // Reset mid-WAIT loses the request
        issue(32'h0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rsp_valid, 0);
        step();
        rst_i = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            step();
            #1;
            chk("midrst_no_rsp", rsp_valid, 0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < DEPTH; i++) load(i, $urandom());
        q.delete();
        begin
            bit          pend;
            int          pend_left;
            logic [31:0] pend_addr;
            bit          e_ready;
            bit          acc;
            bit          pop;
            int          sel;
            exp_t        h;
            pend      = 1'b0;
            pend_left = 0;
            pend_addr = '0;
            for (int c = 0; c < 3000; c++) begin
                sel       = $urandom_range(0, 9);
                req_valid = ($urandom_range(0, 2) != 0);
                case (sel)
                    6:       req_addr = 32'($urandom_range(256, 1000)) << 2;
                    7:       req_addr = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                    8:       req_addr = 32'h3FC;
                    9:       req_addr = $urandom();
                    default: req_addr = 32'($urandom_range(0, 255)) << 2;
                endcase
                rsp_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 24) == 0);
                mem_we    = ($urandom_range(0, 3) == 0);
                mem_waddr = (32'($urandom_range(0, 299)) << 2) | 32'($urandom_range(0, 3));
                mem_wdata = $urandom();
                #1;

                e_ready = !pend && (q.size() < FIFO_DEPTH) && !flush;
                chk("rnd_req_ready", req_ready, e_ready);
                chk("rnd_busy", busy, pend);
                chk("rnd_rsp_valid", rsp_valid, q.size() > 0);
                if (q.size() > 0) begin
                    h = q[0];
                    chk("rnd_rsp_addr", rsp_addr, h.addr);
                    chk("rnd_rsp_instr", rsp_instr, h.instr);
                    chk("rnd_rsp_err", rsp_err, h.err);
                end

                // Model the coming edge
                acc = req_valid && e_ready;
                pop = rsp_ready && (q.size() > 0) && !flush;
                if (flush) begin
                    q.delete();
                    pend = 1'b0;
                end else begin
                    if (pop) void'(q.pop_front());
                    if (pend) begin
                        pend_left--;
                        if (pend_left == 0) begin
                            q.push_back(model_rsp(pend_addr));
                            pend = 1'b0;
                        end
                    end
                end
                if (mem_we && (mem_waddr[31:2] < DEPTH)) mem_m[mem_waddr[31:2]] = mem_wdata;
                if (acc) begin
                    pend      = 1'b1;
                    pend_left = LAT;
                    pend_addr = req_addr;
                end
                step();
            end
        end
        req_valid = 1'b0;
        mem_we    = 1'b0;
        flush     = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-side responder for the pipelined CPU: consumes the fetch address driven by the program counter stage and returns the addressed instruction word after a fixed, parameterised memory latency. It sits between the PC register and the IF/ID pipeline register. It holds a word-addressed instruction store with a loader write port, a single-outstanding request engine, and a small response FIFO, so the consumer can apply back-pressure and the pipeline can flush wrong-path fetches.

## Interface
- DEPTH, 256: instruction words in the store; word index = addr[31:2].
- LAT, 2: read latency in cycles, legal range 1..7.
- FIFO_DEPTH, 2: response FIFO entries, power of two, ≥ 2.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  fetch request present.
- req_ready_o  out  1  request accepted on this edge when high together with req_valid_i.
- req_addr_i  in  32  byte address from the PC stage.
- rsp_valid_o  out  1  FIFO head valid.
- rsp_ready_i  in  1  consumer pops head when high with rsp_valid_o.
- rsp_instr_o  out  32  instruction word at FIFO head.
- rsp_addr_o  out  32  byte address that produced the head entry.
- rsp_err_o  out  1  head entry is an error response.
- flush_i  in  1  discard in-flight and buffered fetches.
- busy_o  out  1  high while in WAIT.
- mem_we_i  in  1  loader write enable.
- mem_waddr_i  in  32  loader byte address; low two bits ignored.
- mem_wdata_i  in  32  loader write data.

## Operation
- FSM states: IDLE, WAIT.
- req_ready_o = (state == IDLE) && FIFO not full && !flush_i.
- Accept in IDLE: latch address, load latency counter with LAT-1, go to WAIT.
- In WAIT with counter ≠ 0: decrement.
- In WAIT with counter = 0: read the store, push {addr, instr, err} into FIFO, return to IDLE.
- Only one request is ever outstanding. Accept requires a free FIFO slot, so a push never meets a full FIFO.
- Out of range (addr[31:2] ≥ DEPTH): instr = 32'h0, err = 1.
- The read samples the store on the completion edge:
  - Loader writes on earlier edges are visible.
  - A write on the completion edge itself is not visible; the old word is returned.
- The store is not reset. Loader writes apply regardless of FSM state.
- flush_i high:
  - FIFO is emptied on that edge.
  - WAIT is aborted to IDLE and its push is suppressed.
  - Any pop on that edge is void.
- Simultaneous push and pop: both take effect; count is unchanged.

## Timing
- Accept on edge T → rsp_valid_o high after edge T+LAT, provided the FIFO was empty.
- Peak throughput: one request per LAT+1 cycles.
- All outputs except req_ready_o are registered or FIFO-head driven.
- Reset values:
  - req_ready_o = 1 (rst_i deasserted, flush_i low).
  - rsp_valid_o = 0, rsp_instr_o = 0, rsp_addr_o = 0, rsp_err_o = 0, busy_o = 0.
  - FSM = IDLE, FIFO empty, counter = 0.
- Reset mid-WAIT: the request is lost and no response is produced.

## Configuration
- IFETCH_MISALIGN_TRAP_EN:
  - Defined: a request with addr[1:0] ≠ 0 completes with instr = 32'h0 and err = 1 after the normal LAT.
  - Undefined: addr[1:0] is ignored; only the range check drives err.

## Structure
- Package ifetch_pkg:
  - fetch-state enum (IDLE, WAIT);
  - response struct {addr, instr, err};
  - LAT bounds and the default NOP word 32'h0.
- Sub-module ifetch_rsp_fifo: synchronous FIFO of response structs with push, pop, flush, full, empty and head outputs.

## Test plan
- Load word 0 = 32'h2001000A; request addr 0 with LAT=2, accept on edge T → rsp_valid_o at T+2 with instr 32'h2001000A, rsp_addr_o 0, rsp_err_o 0.
- Hold rsp_ready_i low and issue addr 0, 4, 8 → first two are buffered; req_ready_o stays low with FIFO full; raising rsp_ready_i drains in order and the third request is then accepted.
- Request addr 0x400 with DEPTH=256 → instr 0, err 1.
- Assert flush_i one cycle after accept → no response appears; FIFO is empty; req_ready_o returns high the cycle after flush.
- Loader writes 32'hDEADBEEF to the pending word one edge before completion → DEADBEEF is returned. The same write on the completion edge → the old word is returned.
- With IFETCH_MISALIGN_TRAP_EN, request addr 2 → err 1, instr 0. Without the macro → word 0 is returned with err 0.
